result_collector: RTL

- Receiving end of the accumulator-valid interface driven by the array controller.
- Captures the skewed per-lane result words of one N x N product as the array asserts a lane's valid, one word per cycle per lane.
- Once all N rows are buffered, streams them out one row per beat on a valid/ready interface toward the output writer.
- Signals completion and protocol errors back to the sequencer.

---
 rtl/result_collector_if.sv | 27 ++
 rtl/result_collector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/result_collector_if.sv
// Handshake bundle between the array controller / sequencer side (master)
// and the result collector (slave).
interface result_collector_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   logic            start_i;
   logic [N-1:0]    acc_valid_i;
   logic [N*DW-1:0] acc_data_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [N*DW-1:0] out_data_o;
   logic            out_last_o;
   logic            busy_o;
   logic            done_o;
   logic            err_o;

   modport master (
      output start_i, acc_valid_i, acc_data_i, out_ready_i,
      input  out_valid_o, out_data_o, out_last_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, acc_valid_i, acc_data_i, out_ready_i,
      output out_valid_o, out_data_o, out_last_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/result_collector.sv
// Buffers the skewed per-lane results of one N x N product, then streams the
// rows out one per valid/ready beat; reports completion and protocol errors.
module result_collector #(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input logic               clk_i,
   input logic               rst_ni,
   result_collector_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] FULL  = CW'(N);
   localparam logic [RW-1:0] RLAST = RW'(N - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   wcnt_q [N];
   logic [CW-1:0]   wcnt_d [N];
   logic [RW-1:0]   rptr_q, rptr_d, nrow;
   logic [DW-1:0]   buf_q [N][N];
   logic [N-1:0]    wr_en, ovf;
   logic            all_full, hs;
   logic [N*DW-1:0] row_next;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic [N*DW-1:0] out_data_q, out_data_d;
   logic            busy_q, done_q, done_d, err_q, err_d;

   assign hs = out_valid_q & bus.out_ready_i;

   always_comb begin
      all_full = 1'b1;
      for (int k = 0; k < N; k++) begin
         wr_en[k] = (state_q == COLLECT) && bus.acc_valid_i[k] && (wcnt_q[k] != FULL);
         ovf[k]   = (state_q == COLLECT) && bus.acc_valid_i[k] && (wcnt_q[k] == FULL);
         if (state_q == IDLE && bus.start_i)
            wcnt_d[k] = '0;
         else
            wcnt_d[k] = wcnt_q[k] + CW'(wr_en[k]);
         if (wcnt_d[k] != FULL)
            all_full = 1'b0;
      end
   end

   // Row to present next; words written on this same edge are forwarded so the
   // first row is correct even when its final word arrives with the last write.
   assign nrow = (state_q == DRAIN) ? rptr_q + RW'(1) : '0;

   always_comb begin
      row_next = '0;
      for (int k = 0; k < N; k++) begin
         if (wr_en[k] && wcnt_q[k] == CW'(nrow))
            row_next[k*DW +: DW] = bus.acc_data_i[k*DW +: DW];
         else
            row_next[k*DW +: DW] = buf_q[nrow][k];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_i) state_d = COLLECT;
         COLLECT: if (all_full) state_d = DRAIN;
         DRAIN:   if (hs && rptr_q == RLAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = err_q;
      rptr_d      = rptr_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i)
               err_d = 1'b0;
            else if (|bus.acc_valid_i)
               err_d = 1'b1;
         end
         COLLECT: begin
            if (|ovf)
               err_d = 1'b1;
            if (all_full) begin
               out_valid_d = 1'b1;
               out_data_d  = row_next;
               out_last_d  = (RLAST == '0);
               rptr_d      = '0;
            end
         end
         DRAIN: begin
            if (|bus.acc_valid_i)
               err_d = 1'b1;
            if (hs) begin
               if (rptr_q == RLAST) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  rptr_d      = '0;
               end else begin
                  rptr_d     = nrow;
                  out_data_d = row_next;
                  out_last_d = (nrow == RLAST);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rptr_q      <= '0;
         for (int k = 0; k < N; k++) wcnt_q[k] <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rptr_q      <= rptr_d;
         for (int k = 0; k < N; k++) wcnt_q[k] <= wcnt_d[k];
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= (state_d != IDLE);
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < N; k++)
         if (wr_en[k])
            buf_q[wcnt_q[k][RW-1:0]][k] <= bus.acc_data_i[k*DW +: DW];
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_last_o  = out_last_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.err_o       = err_q;
endmodule
